// File: rtl/dvi_tmds_if.sv
// Pixel stream into the TMDS encoder and the three encoded symbols out of it.
interface dvi_tmds_if;
  logic [3:0] red_i;
  logic [3:0] green_i;
  logic [3:0] blue_i;
  logic       hsync_i;
  logic       vsync_i;
  logic       dv_de_i;
  logic [9:0] tmds_ch0_o;
  logic [9:0] tmds_ch1_o;
  logic [9:0] tmds_ch2_o;

  modport master (
    output red_i, green_i, blue_i, hsync_i, vsync_i, dv_de_i,
    input  tmds_ch0_o, tmds_ch1_o, tmds_ch2_o
  );

  modport slave (
    input  red_i, green_i, blue_i, hsync_i, vsync_i, dv_de_i,
    output tmds_ch0_o, tmds_ch1_o, tmds_ch2_o
  );
endinterface

// File: rtl/dvi_tmds_encoder.sv
// DVI 1.0 TMDS encoder: 12-bit RGB + sync/DE in, three 10-bit symbols out.
// Two register stages: transition minimization, then DC balance / control insertion.
module dvi_tmds_encoder (
  input  logic        clk,
  input  logic        reset_i,
  dvi_tmds_if.slave   vid
);

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned SYM_W  = 10;
  localparam int unsigned QM_W   = 9;
  localparam int unsigned CNT_W  = 6;

  localparam logic [SYM_W-1:0] CTRL_00 = 10'h354;
  localparam logic [SYM_W-1:0] CTRL_01 = 10'h0AB;
  localparam logic [SYM_W-1:0] CTRL_10 = 10'h154;
  localparam logic [SYM_W-1:0] CTRL_11 = 10'h2AB;

  // Stage 1: XOR/XNOR chain chosen to minimise transitions; q_m[8] flags XOR.
  function automatic logic [QM_W-1:0] minimize(input logic [7:0] d);
    logic [3:0]      n1;
    logic            use_xnor;
    logic [QM_W-1:0] qm;
    n1       = 4'($countones(d));
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    qm       = '0;
    qm[0]    = d[0];
    for (int i = 1; i < 8; i++) begin
      qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    end
    qm[8] = ~use_xnor;
    return qm;
  endfunction

  function automatic logic [SYM_W-1:0] ctrl_sym(input logic [1:0] c);
    case (c)
      2'b01:   return CTRL_01;
      2'b10:   return CTRL_10;
      2'b11:   return CTRL_11;
      default: return CTRL_00;
    endcase
  endfunction

  logic [7:0]             pix_d   [NUM_CH];
  logic [QM_W-1:0]        qm_c    [NUM_CH];
  logic [3:0]             n1_c    [NUM_CH];
  logic [QM_W-1:0]        qm_q    [NUM_CH];
  logic [3:0]             n1_q    [NUM_CH];
  logic                   de_q;
  logic [1:0]             ctrl_q;
  logic [SYM_W-1:0]       sym_c   [NUM_CH];
  logic signed [CNT_W-1:0] cnt_c  [NUM_CH];
  logic signed [CNT_W-1:0] cnt_q  [NUM_CH];
  logic [SYM_W-1:0]       tmds_q  [NUM_CH];

  // Expand each nibble to 8 bits (n*17) and run stage-1 encoding per channel.
  always_comb begin
    pix_d[0] = {vid.blue_i,  vid.blue_i};
    pix_d[1] = {vid.green_i, vid.green_i};
    pix_d[2] = {vid.red_i,   vid.red_i};
    for (int ch = 0; ch < NUM_CH; ch++) begin
      qm_c[ch] = minimize(pix_d[ch]);
      n1_c[ch] = 4'($countones(qm_c[ch][7:0]));
    end
  end

  // Stage-1 register: q_m, its ones count, delayed DE and control bits.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      de_q   <= 1'b0;
      ctrl_q <= 2'b00;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        qm_q[ch] <= '0;
        n1_q[ch] <= '0;
      end
    end else begin
      de_q   <= vid.dv_de_i;
      ctrl_q <= {vid.vsync_i, vid.hsync_i};
      for (int ch = 0; ch < NUM_CH; ch++) begin
        qm_q[ch] <= qm_c[ch];
        n1_q[ch] <= n1_c[ch];
      end
    end
  end

  // Stage 2: DC balance against the running disparity, or control symbol in blanking.
  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      logic signed [CNT_W-1:0] diff;
      logic                    q8;
      sym_c[ch] = ctrl_sym((ch == 0) ? ctrl_q : 2'b00);
      cnt_c[ch] = '0;
      q8        = qm_q[ch][8];
      diff      = $signed({1'b0, n1_q[ch], 1'b0}) - 6'sd8;
      if (de_q) begin
        if ((cnt_q[ch] == 6'sd0) || (diff == 6'sd0)) begin
          sym_c[ch] = {~q8, q8, q8 ? qm_q[ch][7:0] : ~qm_q[ch][7:0]};
          cnt_c[ch] = q8 ? (cnt_q[ch] + diff) : (cnt_q[ch] - diff);
        end else if (((cnt_q[ch] > 6'sd0) && (diff > 6'sd0)) ||
                     ((cnt_q[ch] < 6'sd0) && (diff < 6'sd0))) begin
          sym_c[ch] = {1'b1, q8, ~qm_q[ch][7:0]};
          cnt_c[ch] = cnt_q[ch] + $signed({4'b0, q8, 1'b0}) - diff;
        end else begin
          sym_c[ch] = {1'b0, q8, qm_q[ch][7:0]};
          cnt_c[ch] = cnt_q[ch] - $signed({4'b0, ~q8, 1'b0}) + diff;
        end
      end
    end
  end

  // Output symbol and disparity registers.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        tmds_q[ch] <= CTRL_00;
        cnt_q[ch]  <= '0;
      end
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        tmds_q[ch] <= sym_c[ch];
        cnt_q[ch]  <= cnt_c[ch];
      end
    end
  end

  assign vid.tmds_ch0_o = tmds_q[0];
  assign vid.tmds_ch1_o = tmds_q[1];
  assign vid.tmds_ch2_o = tmds_q[2];

endmodule

// File: tb/tb_dvi_tmds_encoder.sv
// Randomised and directed bench for dvi_tmds_encoder against a behavioural model.
module tb_dvi_tmds_encoder;

  logic clk = 1'b0;
  logic reset_i;

  dvi_tmds_if vid ();

  dvi_tmds_encoder dut (
    .clk     (clk),
    .reset_i (reset_i),
    .vid     (vid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] s0, s1, s2;
    logic       act;
    logic [3:0] r, g, b;
  } exp_t;

  exp_t        expq[$];
  int          m_cnt [3];
  int          dsp   [3];
  logic [29:0] obs_hist [0:255];
  int          cyc;
  int          n_checks;
  int          n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, got, want);
    end
  endtask

  // Reference encoder: stage-1 and stage-2 rules applied in pixel order.
  function automatic logic [9:0] model_sym(input int ch, input logic [7:0] d,
                                           input logic de, input logic [1:0] c);
    int         n1d, n1q, n0q;
    logic       xn, q8;
    logic [7:0] qm;
    logic [9:0] s;
    if (!de) begin
      m_cnt[ch] = 0;
      case (c)
        2'd0: return 10'h354;
        2'd1: return 10'h0AB;
        2'd2: return 10'h154;
        default: return 10'h2AB;
      endcase
    end
    n1d = $countones(d);
    xn  = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    q8  = !xn;
    n1q = $countones(qm);
    n0q = 8 - n1q;
    if (m_cnt[ch] == 0 || n1q == n0q) begin
      s = {~q8, q8, q8 ? qm : ~qm};
      m_cnt[ch] += q8 ? (n1q - n0q) : (n0q - n1q);
    end else if ((m_cnt[ch] > 0 && n1q > n0q) || (m_cnt[ch] < 0 && n0q > n1q)) begin
      s = {1'b1, q8, ~qm};
      m_cnt[ch] += 2 * int'(q8) + (n0q - n1q);
    end else begin
      s = {1'b0, q8, qm};
      m_cnt[ch] += -2 * int'(!q8) + (n1q - n0q);
    end
    return s;
  endfunction

  // Receiver-side decode of a data symbol back to its 8-bit value.
  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] d, o;
    d = s[9] ? ~s[7:0] : s[7:0];
    o[0] = d[0];
    for (int i = 1; i < 8; i++) o[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return o;
  endfunction

  function automatic int sym_disp(input logic [9:0] s);
    return 2 * $countones(s) - 10;
  endfunction

  // One pixel clock: check what is due now, then drive the next pixel.
  task automatic step(input logic rst, input logic [3:0] r, input logic [3:0] g,
                      input logic [3:0] b, input logic hs, input logic vs, input logic de);
    exp_t       e, n;
    logic [9:0] obs [3];
    logic [3:0] nib [3];
    @(negedge clk);
    e = expq.pop_front();
    obs[0] = vid.tmds_ch0_o;
    obs[1] = vid.tmds_ch1_o;
    obs[2] = vid.tmds_ch2_o;
    nib[0] = e.b; nib[1] = e.g; nib[2] = e.r;
    check("ch0", 32'(obs[0]), 32'(e.s0));
    check("ch1", 32'(obs[1]), 32'(e.s1));
    check("ch2", 32'(obs[2]), 32'(e.s2));
    for (int ch = 0; ch < 3; ch++) begin
      if (e.act) begin
        check("decode", 32'(decode(obs[ch])), 32'({nib[ch], nib[ch]}));
        dsp[ch] += sym_disp(obs[ch]);
        check("disparity", 32'((dsp[ch] <= 16) && (dsp[ch] >= -16)), 32'd1);
      end else begin
        dsp[ch] = 0;
      end
    end
    if (cyc < 256) obs_hist[cyc] = {obs[2], obs[1], obs[0]};

    reset_i     = rst;
    vid.red_i   = r;
    vid.green_i = g;
    vid.blue_i  = b;
    vid.hsync_i = hs;
    vid.vsync_i = vs;
    vid.dv_de_i = de;

    if (rst) begin
      for (int ch = 0; ch < 3; ch++) m_cnt[ch] = 0;
      n = '{s0: 10'h354, s1: 10'h354, s2: 10'h354, act: 1'b0, r: 4'h0, g: 4'h0, b: 4'h0};
      expq[0] = n;
      expq.push_back(n);
    end else begin
      n.s0  = model_sym(0, {b, b}, de, {vs, hs});
      n.s1  = model_sym(1, {g, g}, de, 2'b00);
      n.s2  = model_sym(2, {r, r}, de, 2'b00);
      n.act = de;
      n.r = r; n.g = g; n.b = b;
      expq.push_back(n);
    end
    cyc++;
  endtask

  task automatic blank(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pix(input logic [11:0] rgb, input int k);
    for (int i = 0; i < k; i++) step(1'b0, rgb[11:8], rgb[7:4], rgb[3:0], 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int          i_ctl, i_blk, i_wht, i_wht2, i_rst;
    exp_t        z;
    logic [9:0]  ctl_sym [4];
    logic [9:0]  blk_sym [4];
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    for (int ch = 0; ch < 3; ch++) begin m_cnt[ch] = 0; dsp[ch] = 0; end
    reset_i     = 1'b1;
    vid.red_i   = 4'($urandom);
    vid.green_i = 4'($urandom);
    vid.blue_i  = 4'($urandom);
    vid.hsync_i = 1'b0;
    vid.vsync_i = 1'b0;
    vid.dv_de_i = 1'b0;
    z = '{s0: 10'h354, s1: 10'h354, s2: 10'h354, act: 1'b0, r: 4'h0, g: 4'h0, b: 4'h0};
    expq.push_back(z);
    expq.push_back(z);
    repeat (2) @(posedge clk);

    // Reset held with random inputs, then release into plain blanking.
    for (int i = 0; i < 3; i++)
      step(1'b1, 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    blank(4);

    // Control symbols for {vsync,hsync} = 00, 01, 10, 11.
    i_ctl = cyc;
    for (int c = 0; c < 4; c++) step(1'b0, 4'h0, 4'h0, 4'h0, c[0], c[1], 1'b0);

    // Black run after blanking.
    blank(1);
    i_blk = cyc;
    pix(12'h000, 4);

    // Odd-length white run, one blanking clock, then white again.
    blank(1);
    i_wht = cyc;
    pix(12'hFFF, 3);
    blank(1);
    i_wht2 = cyc;
    pix(12'hFFF, 2);

    // Reset in the middle of an active run.
    i_rst = cyc;
    step(1'b1, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0, 1'b1);
    pix(12'h5A3, 1);

    // Single-cycle DE pulses and sync asserted during active video.
    blank(1);
    pix(12'h7C1, 1);
    blank(1);
    step(1'b0, 4'h9, 4'h2, 4'hE, 1'b1, 1'b1, 1'b1);
    blank(3);

    ctl_sym = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    blk_sym = '{10'h100, 10'h3FF, 10'h100, 10'h3FF};
    for (int k = 0; k < 4; k++) begin
      check("ctrl_ch0",  32'(obs_hist[i_ctl + 2 + k][9:0]),   32'(ctl_sym[k]));
      check("ctrl_ch12", 32'(obs_hist[i_ctl + 2 + k][29:10]), 32'({10'h354, 10'h354}));
      check("black",     32'(obs_hist[i_blk + 2 + k]),        32'({3{blk_sym[k]}}));
    end
    check("white_first",  32'(obs_hist[i_wht + 2]),  32'({3{10'h200}}));
    check("white_second", 32'(obs_hist[i_wht + 3]),  32'({3{10'h0FF}}));
    check("disp_cleared", 32'(obs_hist[i_wht2 + 2]), 32'({3{10'h200}}));
    check("midrst_next",  32'(obs_hist[i_rst + 1]),  32'({3{10'h354}}));
    check("midrst_2nd",   32'(obs_hist[i_rst + 2]),  32'({3{10'h354}}));

    // Random soak with bursty DE, random sync and rare resets.
    for (int i = 0; i < 20000; i++) begin
      step(1'($urandom_range(0, 999) == 0),
           4'($urandom), 4'($urandom), 4'($urandom),
           1'($urandom), 1'($urandom),
           1'($urandom_range(0, 9) < 7));
    end
    blank(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
